// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the slow-clock period/high-time meter.
package clk_meas_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } meas_state_e;

   localparam int unsigned CNT_W_DEF       = 28;
   localparam int unsigned TIMEOUT_CYC_DEF = 2**27;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, plus one delay flop
// used to derive single-cycle rise/fall strobes.
module sync_edge_det #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   // Fewer than two stages gives no metastability settling time.
   if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("sync_edge_det: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~dly_q;
   assign fall  = ~level & dly_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk_in
// cycles; back-to-back measurement with a sticky no-edge timeout.
module clk_period_meter
   import clk_meas_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             enable,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             timeout,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYC);

   logic sig_rise, sig_fall, sig_level_unused;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_in (clk_in),
      .rst    (rst),
      .d      (sig_in),
      .level  (sig_level_unused),
      .rise   (sig_rise),
      .fall   (sig_fall)
   );

   meas_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic             hi_open_q, hi_open_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      hi_open_d = hi_open_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;

      if (!enable) begin
         // Drop any partial measurement; published results stay put.
         state_d   = IDLE;
         cnt_d     = '0;
         hcnt_d    = '0;
         hi_open_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d   = ARM;
               cnt_d     = '0;
               hcnt_d    = '0;
               hi_open_d = 1'b0;
            end
            ARM: begin
               if (sig_rise) begin
                  cnt_d     = CNT_ONE;
                  hcnt_d    = CNT_ONE;
                  hi_open_d = 1'b1;
                  state_d   = MEAS;
               end
            end
            MEAS: begin
               // A rise on the timeout cycle still counts as a good edge.
               if (sig_rise) begin
                  period_d  = cnt_q;
                  high_d    = hcnt_q;
                  valid_d   = 1'b1;
                  timeout_d = 1'b0;
                  cnt_d     = CNT_ONE;
                  hcnt_d    = CNT_ONE;
                  hi_open_d = 1'b1;
               end else if (cnt_q >= TO_LIM) begin
                  timeout_d = 1'b1;
                  hi_open_d = 1'b0;
                  state_d   = ARM;
               end else begin
                  cnt_d = sat_inc(cnt_q);
                  if (sig_fall) begin
                     hi_open_d = 1'b0;
                  end else if (hi_open_q) begin
                     hcnt_d = sat_inc(hcnt_q);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         hi_open_q <= 1'b0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         hi_open_q <= hi_open_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign period    = period_q;
   assign high_time = high_q;
   assign valid     = valid_q;
   assign timeout   = timeout_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow, asynchronous square wave, expressed in `clk_in` cycles. It is the receiving end of the frequency-divider path: a divider set to `div_num = N` produces a wave with high time N and period 2N, and this block recovers those numbers. It is used for self-check of divided game-tick clocks and for measuring external slow clocks. Results go to display or debug logic as a registered value with a one-cycle valid strobe.

## Interface
- `CNT_W`, 28: width of the period and high-time counters and outputs.
- `SYNC_STAGES`, 2: number of synchronizer flops on `sig_in`; minimum 2.
- `TIMEOUT_CYC`, 2^27: cycles without a rising edge before a timeout is declared; must be less than 2^CNT_W.
- `clk_in`  input  1  system clock; all logic is on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `sig_in`  input  1  signal to measure; asynchronous to `clk_in`.
- `enable`  input  1  measurement enable; level-sensitive.
- `period`  output  CNT_W  cycles between the last two qualified rising edges.
- `high_time`  output  CNT_W  cycles from a rising edge to the following falling edge, within the last measured period.
- `valid`  output  1  one-cycle pulse when `period` and `high_time` update.
- `timeout`  output  1  sticky flag; set when no rising edge arrives for `TIMEOUT_CYC` cycles; cleared by the next `valid` or by reset.
- `busy`  output  1  high while in the ARM or MEAS states.

## Operation
- **Synchronizer:** `sig_in` passes through `SYNC_STAGES` flops, then one delay flop.
  - `rise` = s & ~d. `fall` = ~s & d.
  - All flops reset to 0.
- **FSM states:** IDLE, ARM, MEAS. Reset state is IDLE.
  - IDLE: the counters are held at 0. When `enable` = 1, go to ARM.
  - ARM: wait for `rise`. On `rise`: set `cnt` = 1 and `hcnt` = 1, set `hi_open` = 1, go to MEAS. The first edge only starts a measurement and never produces `valid`.
  - MEAS: every cycle without `rise`, `cnt` += 1. While `hi_open` = 1, `hcnt` += 1.
  - MEAS, on `fall`: clear `hi_open`. `hcnt` holds its value.
  - MEAS, on `rise`: load `period` ← `cnt` and `high_time` ← `hcnt`, pulse `valid`, clear `timeout`. Restart with `cnt` = 1, `hcnt` = 1, `hi_open` = 1 and stay in MEAS. Measurement is back-to-back, with no lost edge.
  - MEAS, when `cnt` reaches `TIMEOUT_CYC`: set `timeout`, go to ARM. `period` and `high_time` keep their old values.
- **Enable:** `enable` = 0 in any state goes to IDLE on the next cycle. Outputs keep their last values. Any partial measurement is discarded.
- **Arithmetic:** counters are unsigned and saturate at 2^CNT_W−1; they never wrap. `TIMEOUT_CYC` normally fires before saturation.
- **Simultaneous events:** `rise` together with `cnt == TIMEOUT_CYC` counts as a valid edge; timeout is not set.
- **Reset values:**
  - `period` = 0, `high_time` = 0.
  - `valid` = 0, `timeout` = 0, `busy` = 0.
  - `state` = IDLE.
- **Reset mid-measurement:** `rst` clears everything immediately, including the synchronizer. After reset is released, a `sig_in` that is already high reads as a rise, which only arms the FSM.

## Timing
- **Input latency:** a `sig_in` transition reaches `rise`/`fall` `SYNC_STAGES`+1 cycles later. The latency is constant, so measured widths are exact for a `sig_in` that is synchronous to `clk_in`. An asynchronous `sig_in` has ±1 cycle of jitter.
- **Valid timing:** `valid` is registered. It is high in the cycle after the `rise` cycle, and `period`/`high_time` are stable in that same cycle.
- **Update rate:** `valid` fires at most once per input period. The minimum measurable period is 2 cycles, and the minimum high time is 1 cycle.
- **Enable:** `busy` follows state one cycle after `enable` changes.

## Structure
- **Package `clk_meas_pkg`:**
  - state enum (IDLE, ARM, MEAS);
  - default `CNT_W`;
  - default `TIMEOUT_CYC`.
- **Sub-module `sync_edge_det`:**
  - parameter `SYNC_STAGES`;
  - input: `clk_in`, `rst`, `d`;
  - output: `level`, `rise`, `fall`.
- **Top level:** FSM, the two counters, `hi_open` and the output registers.

## Test plan
- **Divider-driven input:** drive `sig_in` from a divider model with N=5 (high 5, low 5), `enable` = 1. Required:
  - the first `valid` follows the second synchronized rise;
  - `period` = 10 and `high_time` = 5;
  - `valid` repeats every 10 cycles.
- **Asymmetric duty:** high 3, low 7, synchronous to `clk_in`. Required: `period` = 10 and `high_time` = 3 on every `valid`.
- **Timeout:** `TIMEOUT_CYC` = 50. After one good measurement (period 10), hold `sig_in` low. Required:
  - `timeout` = 1 exactly 50 cycles after the last rise;
  - `period` stays 10;
  - state is ARM;
  - the next two edges, 20 cycles apart, give `valid` with `period` = 20 and `timeout` = 0.
- **Enable drop:** drop `enable` halfway through a period. Required:
  - `busy` = 0 on the next cycle;
  - no `valid`;
  - outputs unchanged.
  - On re-enable, the first rise only arms, and the second gives a correct period.
- **Reset mid-MEAS:** assert `rst` for 1 cycle during MEAS. Required:
  - all outputs are 0 immediately;
  - restart gives correct values with no spurious `valid`.
- **Rise at timeout boundary:** `TIMEOUT_CYC` = 12, edges 12 cycles apart. Required: `valid` with `period` = 12 and `timeout` = 0.
